// File: rtl/mem_loader.sv
// Program loader: accepts a big-endian byte stream (word count, then words),
// writes the words to consecutive memory addresses and releases the CPU once the image is complete.
module mem_loader #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    MAX_WORDS  = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           words_written
);

  typedef enum logic [2:0] {
    S_HEADER,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [31:0] MAX_COUNT = MAX_WORDS;

  state_t      state;
  state_t      next_state;
  logic [1:0]  byte_cnt;
  logic [23:0] shift;
  logic [31:0] count;
  logic [31:0] assembled;
  logic        take;
  logic        last_byte;

  // Reset gates in_ready so no byte is ever taken while the block restarts.
  assign in_ready  = (state == S_HEADER || state == S_DATA) && !reset;
  assign take      = in_valid && in_ready;
  assign last_byte = take && (byte_cnt == 2'd3);
  assign assembled = {shift, in_data};

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) state <= S_HEADER;
    else       state <= next_state;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    mem_we     = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    cpu_reset  = 1'b1;
    case (state)
      S_HEADER: begin
        if (last_byte) begin
          if (assembled > MAX_COUNT)  next_state = S_ERROR;
          else if (assembled == '0)   next_state = S_DONE;
          else                        next_state = S_DATA;
        end
      end
      S_DATA: begin
        if (last_byte) next_state = S_WRITE;
      end
      S_WRITE: begin
        mem_we = 1'b1;
        if (32'(words_written) + 32'd1 == count) next_state = S_DONE;
        else                                     next_state = S_DATA;
      end
      S_DONE: begin
        done      = 1'b1;
        cpu_reset = 1'b0;
      end
      S_ERROR: begin
        error = 1'b1;
      end
      default: next_state = S_HEADER;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt      <= 2'd0;
      shift         <= '0;
      count         <= '0;
      words_written <= '0;
      mem_addr      <= BASE_ADDR;
      mem_wdata     <= '0;
    end else begin
      if (take) begin
        shift    <= assembled[23:0];
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (state == S_HEADER && last_byte) count <= assembled;
      // Address and data are captured with the 4th byte so they are stable for the whole write cycle.
      if (state == S_DATA && last_byte) begin
        mem_addr  <= BASE_ADDR + ADDR_WIDTH'({words_written, 2'b00});
        mem_wdata <= assembled;
      end
      if (state == S_WRITE) begin
        words_written <= words_written + 16'd1;
        byte_cnt      <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: a byte-position model predicts every output each cycle,
// and directed loads pin the observed writes against hand-computed literals.
module tb_mem_loader;

  localparam int          AW   = 32;
  localparam logic [31:0] BASE = 32'h0;
  localparam int          MAXW = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;
  logic [15:0] words_written;

  always #5 clk = ~clk;

  mem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_reset(cpu_reset), .done(done),
    .error(error), .words_written(words_written)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] wlog[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: tracks how many bytes have been accepted since reset and derives
  // header/word boundaries, write slots and completion from that position.
  bit          model_valid = 0;
  int          nacc = 0;
  int          m_written = 0;
  logic [31:0] m_count = '0, m_word = '0, m_addr = '0, m_wdata = '0;
  bit          m_wr = 0, m_done = 0, m_err = 0;

  always @(posedge clk) begin
    if (reset) begin
      model_valid = 1; nacc = 0; m_written = 0; m_count = '0; m_word = '0;
      m_addr = BASE; m_wdata = '0; m_wr = 0; m_done = 0; m_err = 0;
    end else if (model_valid) begin
      if (m_wr) begin
        m_wr = 0;
        m_written++;
        if (m_written == int'(m_count)) m_done = 1;
      end else if (!m_done && !m_err && in_valid) begin
        if (nacc < 4) begin
          m_count = {m_count[23:0], in_data};
          nacc++;
          if (nacc == 4) begin
            if (m_count > MAXW)      m_err = 1;
            else if (m_count == 0)   m_done = 1;
          end
        end else begin
          m_word = {m_word[23:0], in_data};
          nacc++;
          if ((nacc - 4) % 4 == 0) begin
            m_wr    = 1;
            m_addr  = BASE + 32'(m_written * 4);
            m_wdata = m_word;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("in_ready", 64'(in_ready), 64'(!reset && !m_wr && !m_done && !m_err));
      check("mem_we", 64'(mem_we), 64'(m_wr));
      check("mem_addr", 64'(mem_addr), 64'(m_addr));
      check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
      check("done", 64'(done), 64'(m_done));
      check("error", 64'(error), 64'(m_err));
      check("cpu_reset", 64'(cpu_reset), 64'(!m_done));
      check("words_written", 64'(words_written), 64'(m_written));
      if (mem_we === 1'b1) wlog.push_back({mem_addr, mem_wdata});
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; in_valid = 1'b0;
    repeat (n) sync();
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int idle);
    bit got = 0;
    in_valid = 1'b0;
    repeat (idle) sync();
    in_valid = 1'b1; in_data = b;
    for (int t = 0; t < 16 && !got; t++) begin
      @(negedge clk);
      if (in_ready === 1'b1) got = 1;
      sync();
    end
    in_valid = 1'b0;
    check("accept", 64'(got), 64'd1);
  endtask

  task automatic send_seq(input logic [7:0] bytes[], input bit bursty);
    foreach (bytes[i]) send_byte(bytes[i], bursty ? int'($urandom_range(0, 3)) : 0);
  endtask

  task automatic wait_end(input string name);
    bit seen = 0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      if (done === 1'b1 || error === 1'b1) seen = 1;
    end
    check({name, "_end"}, 64'(done | error), 64'd1);
  endtask

  task automatic check_two_word(input string name);
    check({name, "_nwrites"}, 64'(wlog.size()), 64'd2);
    if (wlog.size() == 2) begin
      check({name, "_w0"}, wlog[0], {32'h0, 32'h2002003a});
      check({name, "_w1"}, wlog[1], {32'h4, 32'h0000000c});
    end
    check({name, "_done"}, 64'(done), 64'd1);
    check({name, "_cpu_reset"}, 64'(cpu_reset), 64'd0);
    check({name, "_ww"}, 64'(words_written), 64'd2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1);
  end

  initial begin
    logic [7:0] two_word[] = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h20, 8'h02, 8'h00, 8'h3a,
                               8'h00, 8'h00, 8'h00, 8'h0c};
    logic [7:0] zero_cnt[] = '{8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] over_cnt[] = '{8'h00, 8'h00, 8'h10, 8'h01};
    logic [7:0] max_cnt[]  = '{8'h00, 8'h00, 8'h10, 8'h00};
    logic [7:0] partial[]  = '{8'h00, 8'h00, 8'h00, 8'h01, 8'haa, 8'hbb};
    logic [7:0] one_word[] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    int n;

    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    sync();
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    check("rst_ww", 64'(words_written), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'(BASE));
    check("rst_wdata", 64'(mem_wdata), 64'd0);
    sync();
    reset = 1'b0;

    wlog.delete();
    send_seq(two_word, 0);
    wait_end("two_word");
    check_two_word("two_word");

    sync(); do_reset(1); wlog.delete();
    send_seq(zero_cnt, 0);
    @(negedge clk);
    check("zero_done", 64'(done), 64'd1);
    check("zero_cpu_reset", 64'(cpu_reset), 64'd0);
    repeat (3) @(negedge clk);
    check("zero_in_ready", 64'(in_ready), 64'd0);
    check("zero_nwrites", 64'(wlog.size()), 64'd0);

    sync(); do_reset(1); wlog.delete();
    send_seq(over_cnt, 0);
    @(negedge clk);
    check("over_error", 64'(error), 64'd1);
    check("over_cpu_reset", 64'(cpu_reset), 64'd1);
    check("over_in_ready", 64'(in_ready), 64'd0);
    repeat (3) @(negedge clk);
    check("over_done", 64'(done), 64'd0);
    check("over_nwrites", 64'(wlog.size()), 64'd0);

    sync(); do_reset(1); wlog.delete();
    send_seq(max_cnt, 0);
    repeat (3) @(negedge clk);
    check("max_error", 64'(error), 64'd0);
    check("max_in_ready", 64'(in_ready), 64'd1);

    sync(); do_reset(1); wlog.delete();
    send_seq(two_word, 1);
    wait_end("bursty");
    check_two_word("bursty");

    sync(); do_reset(1);
    send_seq(partial, 0);
    do_reset(1); wlog.delete();
    send_seq(one_word, 0);
    wait_end("midrst");
    check("midrst_nwrites", 64'(wlog.size()), 64'd1);
    if (wlog.size() == 1) check("midrst_w0", wlog[0], {BASE, 32'h12345678});
    check("midrst_ww", 64'(words_written), 64'd1);
    check("midrst_done", 64'(done), 64'd1);

    sync();
    n = wlog.size();
    in_valid = 1'b1; in_data = 8'h55;
    repeat (12) sync();
    in_valid = 1'b0;
    @(negedge clk);
    check("post_nwrites", 64'(wlog.size()), 64'(n));
    check("post_done", 64'(done), 64'd1);
    check("post_cpu_reset", 64'(cpu_reset), 64'd0);
    sync(); do_reset(1);
    @(negedge clk);
    check("post_rst_done", 64'(done), 64'd0);
    check("post_rst_cpu_reset", 64'(cpu_reset), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
